// File: rtl/nor_fanout_pkg.sv
// Shared types and helpers for the NOR fanout pulse tester.
`default_nettype none

package nor_fanout_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HIGH  = 3'd1,
      LOW   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // An odd total inversion count flips the leaf relative to the stimulus.
   function automatic logic pol(input int stem, input int branch);
      return ((stem + branch) % 2) == 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/NOR2_X1.sv
// Behavioural model of the NOR2_X1 standard cell.
`default_nettype none

module NOR2_X1 (
   input  logic A1,
   input  logic A2,
   output logic ZN
);

   assign ZN = ~(A1 | A2);

endmodule

`default_nettype wire

// File: rtl/nor_chain.sv
// Chain of DEPTH NOR2_X1 stages with A2 tied low, acting as inverters.
`default_nettype none

module nor_chain #(
   parameter int DEPTH = 4
) (
   input  logic in,
   output logic out
);

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic w_a;
      logic w_z;
      if (k == 0) begin : g_first
         assign w_a = in;
      end else begin : g_next
         assign w_a = g_stage[k-1].w_z;
      end
      NOR2_X1 u_nor (
         .A1 (w_a),
         .A2 (1'b0),
         .ZN (w_z)
      );
   end

   assign out = g_stage[DEPTH-1].w_z;

endmodule

`default_nettype wire

// File: rtl/nor_fanout_pulse_tester.sv
// Pulse-train harness: drives a NOR stem/branch tree and counts surviving pulses per leaf.
`default_nettype none

module nor_fanout_pulse_tester
   import nor_fanout_pkg::*;
#(
   parameter int STEM_DEPTH   = 6,
   parameter int BRANCHES     = 4,
   parameter int BRANCH_DEPTH = 4,
   parameter int PW_W         = 8,
   parameter int NP_W         = 8,
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYC    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [PW_W-1:0]           pulse_width,
   input  logic [PW_W-1:0]           gap_width,
   input  logic [NP_W-1:0]           num_pulses,
   output logic                      busy,
   output logic                      done,
   output logic [BRANCHES*CNT_W-1:0] branch_cnt,
   output logic [BRANCHES-1:0]       mismatch,
   output logic [BRANCHES-1:0]       leaf
);

   localparam logic            POL     = pol(STEM_DEPTH, BRANCH_DEPTH);
   localparam int              DR_W    = $clog2(DRAIN_CYC + 1);
   localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYC - 1);

   state_t                          r_state;
   state_t                          w_next;
   logic [PW_W-1:0]                 r_pw;
   logic [PW_W-1:0]                 r_gap;
   logic [NP_W-1:0]                 r_np;
   logic [PW_W-1:0]                 r_phase;
   logic [DR_W-1:0]                 r_drain;
   logic [NP_W:0]                   r_sent;
   logic                            r_stim;
   logic                            r_busy;
   logic                            r_done;
   logic [BRANCHES-1:0]             r_sync1;
   logic [BRANCHES-1:0]             r_sync2;
   logic [BRANCHES-1:0]             r_sync3;
   logic [BRANCHES-1:0]             r_mismatch;
   logic [BRANCHES-1:0][CNT_W-1:0]  r_cnt;

   logic                            w_stem;
   logic [BRANCHES-1:0]             w_leaf;
   logic [BRANCHES-1:0]             w_rise;
   logic [PW_W-1:0]                 w_pw_last;
   logic [PW_W-1:0]                 w_gap_last;
   logic                            w_accept;

   // ---------------- device under measurement ----------------
   nor_chain #(.DEPTH(STEM_DEPTH)) u_stem (
      .in  (r_stim),
      .out (w_stem)
   );

   for (genvar b = 0; b < BRANCHES; b++) begin : g_branch
      logic w_leaf_bit;
      nor_chain #(.DEPTH(BRANCH_DEPTH)) u_branch (
         .in  (w_stem),
         .out (w_leaf_bit)
      );
      assign w_leaf[b] = w_leaf_bit;
   end

   // ---------------- sequencing ----------------
   // Zero-length phases are clamped to one cycle.
   assign w_pw_last  = (r_pw  == '0) ? '0 : r_pw  - 1'b1;
   assign w_gap_last = (r_gap == '0) ? '0 : r_gap - 1'b1;
   assign w_accept   = (r_state == IDLE) && start;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = (num_pulses == '0) ? DRAIN : HIGH;
         HIGH:    if (r_phase == w_pw_last) w_next = LOW;
         LOW:     if (r_phase == w_gap_last)
                     w_next = (r_sent < {1'b0, r_np}) ? HIGH : DRAIN;
         DRAIN:   if (r_drain == DR_LAST) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_pw    <= '0;
         r_gap   <= '0;
         r_np    <= '0;
         r_phase <= '0;
         r_drain <= '0;
         r_sent  <= '0;
         r_stim  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_stim  <= (w_next == HIGH);
         r_busy  <= (w_next == HIGH) || (w_next == LOW) || (w_next == DRAIN);
         r_done  <= (w_next == DONE);
         if (w_accept) begin
            r_pw  <= pulse_width;
            r_gap <= gap_width;
            r_np  <= num_pulses;
         end
         if ((w_next == r_state) && ((r_state == HIGH) || (r_state == LOW)))
            r_phase <= r_phase + 1'b1;
         else
            r_phase <= '0;
         if ((r_state == DRAIN) && (w_next == DRAIN))
            r_drain <= r_drain + 1'b1;
         else
            r_drain <= '0;
         if (w_accept)
            r_sent <= '0;
         else if ((r_state == HIGH) && (w_next == LOW))
            r_sent <= r_sent + 1'b1;
      end
   end

   // ---------------- measurement ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= w_leaf ^ {BRANCHES{POL}};
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_rise = r_sync2 & ~r_sync3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_mismatch <= '0;
      end else if (w_accept) begin
         r_cnt      <= '0;
         r_mismatch <= '0;
      end else begin
         for (int i = 0; i < BRANCHES; i++) begin
            if (r_busy && w_rise[i] && (r_cnt[i] != {CNT_W{1'b1}}))
               r_cnt[i] <= r_cnt[i] + 1'b1;
         end
         // Evaluated on entry to DONE so mismatch is valid alongside done.
         if ((r_state == DRAIN) && (w_next == DONE)) begin
            for (int i = 0; i < BRANCHES; i++)
               r_mismatch[i] <= (r_cnt[i] != CNT_W'(r_np));
         end
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign branch_cnt = r_cnt;
   assign mismatch   = r_mismatch;
   assign leaf       = w_leaf;

endmodule

`default_nettype wire

// File: tb/tb_nor_fanout_pulse_tester.sv
// Self-checking bench: vector table with scoreboard, plus reset and re-start sequences.
`default_nettype none

module tb_nor_fanout_pulse_tester;

   localparam int BR = 4;
   localparam int CW = 16;
   localparam int SD = 6;
   localparam int BD = 4;
   localparam logic LEAF_IDLE = ((SD + BD) % 2) == 1;

   typedef struct {
      logic [7:0]  pw;
      logic [7:0]  gap;
      logic [7:0]  np;
      int          lat;
      int          cnt;
      logic [3:0]  mm;
      bit          inj;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [7:0] pulse_width;
   logic [7:0] gap_width;
   logic [7:0] num_pulses;
   logic busy;
   logic done;
   logic [BR*CW-1:0] branch_cnt;
   logic [BR-1:0] mismatch;
   logic [BR-1:0] leaf;

   int total = 0;
   int bad = 0;
   vec_t sb[$];
   vec_t vecs[7];

   always #5 clk = ~clk;

   nor_fanout_pulse_tester dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pulse_width (pulse_width),
      .gap_width   (gap_width),
      .num_pulses  (num_pulses),
      .busy        (busy),
      .done        (done),
      .branch_cnt  (branch_cnt),
      .mismatch    (mismatch),
      .leaf        (leaf)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      vec_t e;
      int   cyc;
      bit   seen;
      pulse_width = v.pw;
      gap_width   = v.gap;
      num_pulses  = v.np;
      start       = 1'b1;
      sb.push_back(v);
      tick();
      start       = 1'b0;
      pulse_width = 8'($urandom);
      gap_width   = 8'($urandom);
      num_pulses  = 8'($urandom);
      cyc = 2;
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      if (v.inj) force dut.g_branch[2].w_leaf_bit = 1'b0;
      seen = 1'b0;
      while (!seen && cyc <= v.lat + 20) begin
         if (done) seen = 1'b1;
         else begin
            tick();
            cyc++;
         end
      end
      if (v.inj) release dut.g_branch[2].w_leaf_bit;
      e = sb.pop_front();
      chk("done_seen", {63'd0, seen}, 64'd1);
      chk("latency", 64'(cyc), 64'(e.lat));
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      for (int b = 0; b < BR; b++)
         chk($sformatf("branch_cnt[%0d]", b), 64'(branch_cnt[b*CW +: CW]),
             (e.inj && b == 2) ? 64'd0 : 64'(e.cnt));
      chk("mismatch", 64'(mismatch), 64'(e.mm));
      tick();
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("cnt_hold", 64'(branch_cnt[0 +: CW]), 64'(e.inj ? e.cnt : e.cnt));
   endtask

   initial begin
      int dcount;
      int cyc;
      vecs[0] = '{pw: 8'd3, gap: 8'd3, np: 8'd5, lat: 40, cnt: 5, mm: 4'b0000, inj: 1'b0};
      vecs[1] = '{pw: 8'd0, gap: 8'd0, np: 8'd2, lat: 14, cnt: 2, mm: 4'b0000, inj: 1'b0};
      vecs[2] = '{pw: 8'd0, gap: 8'd0, np: 8'd0, lat: 10, cnt: 0, mm: 4'b0000, inj: 1'b0};
      vecs[3] = '{pw: 8'd1, gap: 8'd2, np: 8'd3, lat: 19, cnt: 3, mm: 4'b0000, inj: 1'b0};
      vecs[4] = '{pw: 8'd5, gap: 8'd0, np: 8'd4, lat: 34, cnt: 4, mm: 4'b0000, inj: 1'b0};
      vecs[5] = '{pw: 8'd4, gap: 8'd7, np: 8'd2, lat: 32, cnt: 2, mm: 4'b0000, inj: 1'b0};
      vecs[6] = '{pw: 8'd3, gap: 8'd3, np: 8'd5, lat: 40, cnt: 5, mm: 4'b0100, inj: 1'b1};

      rst = 1'b1;
      start = 1'b0;
      pulse_width = '0;
      gap_width = '0;
      num_pulses = '0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_cnt", 64'(branch_cnt), 64'd0);
      chk("reset_mismatch", 64'(mismatch), 64'd0);
      chk("reset_leaf", 64'(leaf), 64'({BR{LEAF_IDLE}}));

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset in the high phase of pulse 3, with a stray start mid-run.
      pulse_width = 8'd3; gap_width = 8'd3; num_pulses = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 2;
      repeat (4) begin tick(); cyc++; end
      start = 1'b1;
      tick(); cyc++;
      start = 1'b0;
      while (cyc < 14) begin tick(); cyc++; end
      chk("mid_high_leaf", 64'(leaf), 64'({BR{~LEAF_IDLE}}));
      chk("mid_cnt_b0", 64'(branch_cnt[0 +: CW]), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_busy", {63'd0, busy}, 64'd0);
      chk("async_rst_cnt", 64'(branch_cnt), 64'd0);
      chk("async_rst_leaf", 64'(leaf), 64'({BR{LEAF_IDLE}}));
      tick();
      rst = 1'b0;
      dcount = 0;
      repeat (60) begin tick(); if (done) dcount++; end
      chk("no_done_after_rst", 64'(dcount), 64'd0);
      chk("idle_after_rst", {63'd0, busy}, 64'd0);

      // Second start during busy must be ignored.
      pulse_width = 8'd2; gap_width = 8'd2; num_pulses = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 2;
      dcount = 0;
      repeat (3) begin tick(); cyc++; end
      pulse_width = 8'd1; gap_width = 8'd1; num_pulses = 8'd7; start = 1'b1;
      tick(); cyc++;
      start = 1'b0;
      while (dcount == 0 && cyc < 60) begin
         tick(); cyc++;
         if (done) dcount++;
      end
      chk("restart_latency", 64'(cyc), 64'd22);
      chk("restart_cnt_b3", 64'(branch_cnt[3*CW +: CW]), 64'd3);
      chk("restart_mismatch", 64'(mismatch), 64'd0);
      repeat (50) begin tick(); if (done) dcount++; end
      chk("restart_single_done", 64'(dcount), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
